// File: rtl/alu_seq_8b.sv
// alu_seq_8b: 8-bit sequential ALU front-end that runs two nibble passes
// through an external combinational 4-bit ALU (low nibble, then high nibble).
// Optional signed overflow output is enabled with `define ALU_SEQ_OVF_EN.
module alu_seq_8b (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_s,
    output logic       alu_cin,
    input  logic [3:0] alu_f,
    input  logic       alu_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic       ovf
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_RSV = 3'b111;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_c_lo;
    logic [7:0] r_result;
    logic       r_carry;
    logic       r_zero;
    logic       w_arith;
    logic [3:0] w_f;

    // add/sub chain the low-nibble carry into the high pass
    assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
    // reserved op always yields zero regardless of what the ALU returns
    assign w_f     = (r_op == OP_RSV) ? 4'h0 : alu_f;

    assign result  = r_result;
    assign carry   = r_carry;
    assign zero    = r_zero;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = LO;
            LO:      w_next = HI;
            HI:      w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // outputs: handshake and ALU drive per state
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        alu_s     = 3'b000;
        alu_cin   = 1'b0;
        case (r_state)
            LO: begin
                alu_a = r_a[3:0];
                alu_b = r_b[3:0];
                alu_s = r_op;
            end
            HI: begin
                alu_a = r_a[7:4];
                if (r_op == OP_ADD) begin
                    alu_s   = OP_ADD;
                    alu_b   = r_b[7:4];
                    alu_cin = r_c_lo;
                end else if (r_op == OP_SUB) begin
                    // high nibble of a subtract is a + ~b + borrow-chain carry
                    alu_s   = OP_ADD;
                    alu_b   = ~r_b[7:4];
                    alu_cin = r_c_lo;
                end else begin
                    alu_s = r_op;
                    alu_b = r_b[7:4];
                end
            end
            default: ;
        endcase
    end

    // request capture, only when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= 3'b000;
            r_a  <= 8'h00;
            r_b  <= 8'h00;
        end else if (r_state == IDLE && in_valid) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
        end
    end

    // result and flags: low nibble in LO, high nibble and flags in HI
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= 8'h00;
            r_c_lo   <= 1'b0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
        end else if (r_state == LO) begin
            r_result[3:0] <= w_f;
            r_c_lo        <= alu_cout;
        end else if (r_state == HI) begin
            r_result[7:4] <= w_f;
            r_carry       <= w_arith & alu_cout;
            r_zero        <= ({w_f, r_result[3:0]} == 8'h00);
        end
    end

`ifdef ALU_SEQ_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;

    // signed overflow from operand signs and the new result sign bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == HI) begin
            if (r_op == OP_ADD)
                r_ovf <= (r_a[7] == r_b[7]) && (w_f[3] != r_a[7]);
            else if (r_op == OP_SUB)
                r_ovf <= (r_a[7] != r_b[7]) && (w_f[3] != r_a[7]);
            else
                r_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_8b.sv
// Directed bench for alu_seq_8b with a behavioural 4-bit ALU and a
// scoreboard of expected 8-bit results computed from whole-byte arithmetic.
module tb_alu_seq_8b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a, b;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_s;
    logic       alu_cin;
    logic [3:0] alu_f;
    logic       alu_cout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry, zero;
`ifdef ALU_SEQ_OVF_EN
    logic       ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       v;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_seq_8b dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero)
`ifdef ALU_SEQ_OVF_EN
        , .ovf(ovf)
`endif
    );

    // external 4-bit ALU: sub is a + ~b + 1, cout=1 means no borrow
    always_comb begin
        alu_f    = 4'h0;
        alu_cout = 1'b0;
        case (alu_s)
            3'b000: alu_f = alu_a;
            3'b001: {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_cin};
            3'b010: {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
            3'b011: alu_f = alu_a & alu_b;
            3'b100: alu_f = alu_a | alu_b;
            3'b101: alu_f = alu_a ^ alu_b;
            3'b110: alu_f = ~alu_a;
            default: alu_f = 4'h0;
        endcase
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        logic [8:0] s;
        e.r = 8'h00; e.c = 1'b0; e.v = 1'b0;
        case (o)
            3'b000: e.r = x;
            3'b001: begin
                s = {1'b0, x} + {1'b0, y};
                e.r = s[7:0]; e.c = s[8];
                e.v = (x[7] == y[7]) && (e.r[7] != x[7]);
            end
            3'b010: begin
                e.r = x - y; e.c = (x >= y);
                e.v = (x[7] != y[7]) && (e.r[7] != x[7]);
            end
            3'b011: e.r = x & y;
            3'b100: e.r = x | y;
            3'b101: e.r = x ^ y;
            3'b110: e.r = ~x;
            default: e.r = 8'h00;
        endcase
        e.z = (e.r == 8'h00);
        return e;
    endfunction

    // issue one request, check ALU drive in LO/HI, latency, result, then drain
    task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input int hold);
        exp_t e;
        logic ex_cin;
        logic [4:0] lo_sum;
        @(negedge clk);
        check("in_ready_before", {15'd0, in_ready}, 16'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        out_ready = (hold == 0);
        sb.push_back(model(o, x, y));
        @(posedge clk); #1;
        in_valid = 1'b0;
        // LO
        check("lo_alu_s", {13'd0, alu_s}, {13'd0, o});
        check("lo_alu_a", {12'd0, alu_a}, {12'd0, x[3:0]});
        check("lo_cin", {15'd0, alu_cin}, 16'd0);
        check("lo_out_valid", {15'd0, out_valid}, 16'd0);
        @(posedge clk); #1;
        // HI
        lo_sum = {1'b0, x[3:0]} + {1'b0, y[3:0]};
        ex_cin = (o == 3'b001) ? lo_sum[4] : (o == 3'b010) ? (x[3:0] >= y[3:0]) : 1'b0;
        check("hi_alu_s", {13'd0, alu_s}, {13'd0, ((o == 3'b010) ? 3'b001 : o)});
        check("hi_alu_a", {12'd0, alu_a}, {12'd0, x[7:4]});
        check("hi_cin", {15'd0, alu_cin}, {15'd0, ex_cin});
        check("hi_out_valid", {15'd0, out_valid}, 16'd0);
        @(posedge clk); #1;
        // DONE, two edges after acceptance
        check("done_out_valid", {15'd0, out_valid}, 16'd1);
        e = sb.pop_front();
        check("result", {8'd0, result}, {8'd0, e.r});
        check("carry", {15'd0, carry}, {15'd0, e.c});
        check("zero", {15'd0, zero}, {15'd0, e.z});
`ifdef ALU_SEQ_OVF_EN
        check("ovf", {15'd0, ovf}, {15'd0, e.v});
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_out_valid", {15'd0, out_valid}, 16'd1);
            check("hold_in_ready", {15'd0, in_ready}, 16'd0);
            check("hold_result", {7'd0, carry, result}, {7'd0, e.c, e.r});
            in_valid = (i == 1);
            op = 3'b110; a = 8'h55; b = 8'h00;
        end
        if (hold > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("drain_out_valid", {15'd0, out_valid}, 16'd0);
        check("drain_in_ready", {15'd0, in_ready}, 16'd1);
        check("held_after_done", {8'd0, result}, {8'd0, e.r});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00; out_ready = 1'b1;
        #3;
        check("rst_result", {8'd0, result}, 16'h0000);
        check("rst_flags", {14'd0, carry, zero}, 16'd0);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_alu_drive", {5'd0, alu_a, alu_b, alu_s}, 16'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        do_op(3'b001, 8'h3C, 8'h4F, 0);   // 0x8B, c0, ovf1
        do_op(3'b010, 8'h10, 8'h01, 0);   // 0x0F, c1
        do_op(3'b010, 8'h01, 8'h02, 0);   // 0xFF, c0
        do_op(3'b101, 8'hA5, 8'hA5, 0);   // 0x00, z1
        do_op(3'b110, 8'h0F, 8'h00, 0);   // 0xF0
        do_op(3'b000, 8'h9A, 8'h33, 0);
        do_op(3'b011, 8'hC3, 8'h5A, 0);
        do_op(3'b100, 8'h81, 8'h18, 0);
        do_op(3'b111, 8'hFF, 8'hFF, 0);   // reserved -> 0x00, z1
        do_op(3'b001, 8'hFF, 8'h01, 0);   // 0x00, c1, z1
        do_op(3'b010, 8'h77, 8'h77, 0);   // 0x00, c1, z1
        do_op(3'b010, 8'h80, 8'h01, 0);   // signed overflow on sub
        do_op(3'b001, 8'h12, 8'h34, 5);   // backpressure, 0x46

        // reset while in HI: aborted, no out_valid, clean restart
        @(negedge clk);
        op = 3'b001; a = 8'h12; b = 8'h34; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_hi_alu_s", {13'd0, alu_s}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_result", {8'd0, result}, 16'h0000);
        check("midrst_out_valid", {15'd0, out_valid}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_valid", {15'd0, out_valid}, 16'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_in_ready", {15'd0, in_ready}, 16'd1);
        check("postrst_out_valid", {15'd0, out_valid}, 16'd0);
        check("postrst_result", {8'd0, result}, 16'h0000);

        do_op(3'b001, 8'h7F, 8'h01, 0);   // 0x80, ovf1

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_8b.md
ALU_SEQ_8B -- requirements
Module: alu_seq_8b

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port in_valid  input  1  request valid.
REQ-004 SHALL have port in_ready  output  1  block can accept a request.
REQ-005 SHALL have port op  input  3  operation code; same encoding as the 4-bit ALU S field (000 pass A, 001 add, 010 sub, 011 AND, 100 OR, 101 XOR, 110 NOT A, 111 reserved).
REQ-006 SHALL have ports a, b  input  8  operands.
REQ-007 SHALL have ports alu_a, alu_b  output  4; alu_s  output  3; alu_cin  output  1  drive the 4-bit ALU.
REQ-008 SHALL have ports alu_f  input  4; alu_cout  input  1  results returned by the 4-bit ALU (combinational, same cycle).
REQ-009 SHALL have ports out_valid  output  1; out_ready  input  1  result handshake.
REQ-010 SHALL have ports result  output  8; carry  output  1; zero  output  1  registered result and flags.

Function
REQ-011 SHALL implement FSM states IDLE, LO, HI, DONE.
REQ-012 SHALL assert in_ready only in IDLE; in_valid & in_ready SHALL capture op, a, b and go to LO.
REQ-013 In LO SHALL drive alu_a=a[3:0], alu_b=b[3:0], alu_s=op, alu_cin=0; SHALL register alu_f into result[3:0] and alu_cout into internal c_lo; next state HI.
REQ-014 In HI for op 001 SHALL drive alu_s=001, alu_a=a[7:4], alu_b=b[7:4], alu_cin=c_lo.
REQ-015 In HI for op 010 SHALL drive alu_s=001, alu_a=a[7:4], alu_b=~b[7:4], alu_cin=c_lo (borrow chain through add path).
REQ-016 In HI for all other ops SHALL drive alu_s=op, alu_a=a[7:4], alu_b=b[7:4], alu_cin=0.
REQ-017 In HI SHALL register alu_f into result[7:4]; carry=alu_cout for ops 001/010, else 0; zero=1 iff full 8-bit result is 0x00; next state DONE.
REQ-018 In IDLE and DONE SHALL drive alu_a=0, alu_b=0, alu_s=000, alu_cin=0.
REQ-019 SHALL assert out_valid only in DONE; out_valid & out_ready SHALL return to IDLE; out_ready low SHALL hold DONE with result/flags stable.
REQ-020 Latency: request accepted at edge N SHALL give out_valid high after edge N+2; minimum issue interval 4 cycles with out_ready held high.
REQ-021 For sub, carry=1 SHALL mean a >= b unsigned (no borrow); carry=0 means borrow.
REQ-022 op 111 SHALL complete normally with result 0x00, carry 0, zero 1.
REQ-023 result, carry, zero SHALL hold their last values outside HI until the next HI update.
REQ-024 in_valid while not in IDLE SHALL be ignored (no capture, no state change).

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, result 0x00, carry 0, zero 0, c_lo 0, out_valid 0, captured operands 0, regardless of clock.
REQ-026 Reset mid-operation (LO/HI/DONE) SHALL abort it with no out_valid pulse; in_ready SHALL be 1 on the first cycle after rst_n rises.

Configuration
REQ-027 With macro ALU_SEQ_OVF_EN defined SHALL add output ovf (1 bit, reset 0), registered in HI: op 001 ovf=(a[7]==b[7])&(result[7]!=a[7]); op 010 ovf=(a[7]!=b[7])&(result[7]!=a[7]); else 0.
REQ-028 Without ALU_SEQ_OVF_EN the ovf port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 add a=0x3C b=0x4F -> result 0x8B, carry 0, zero 0, ovf 1 (if enabled); out_valid after 2 edges.
REQ-030 sub a=0x10 b=0x01 -> result 0x0F, carry 1; sub a=0x01 b=0x02 -> result 0xFF, carry 0.
REQ-031 xor a=0xA5 b=0xA5 -> result 0x00, zero 1, carry 0; NOT a=0x0F -> result 0xF0.
REQ-032 add 0x12+0x34 with out_ready low 5 cycles -> out_valid held, result 0x46 stable, in_ready 0, second in_valid ignored.
REQ-033 rst_n pulsed low while in HI -> out_valid never asserts, result 0x00, in_ready 1 after release.
